decoder_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource among 4 requesters.
//  The winner is held as a 2-bit address. A 2-to-4 line decode of that

---
 rtl/decoder_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 4 requesters sharing one resource.
// The winner is kept as a 2-bit address; the one-hot grant bus is the
// registered decode of that address gated by grant_valid. A tenure lasts
// until the winner drops its request or HOLD_MAX cycles elapse (preempt).
// Every tenure is followed by one GAP cycle and one IDLE cycle.
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             preempt_q, preempt_d;
  logic [3:0]       grant_q, grant_d;

  logic [1:0]       cand [4];
  logic             win_found;
  logic [1:0]       win_idx;
  logic             preempt_evt;

  // Search order: ptr, ptr+1, ptr+2, ptr+3 (2-bit add wraps 3->0)
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = ptr_q + 2'(gi);
    end
  endgenerate

  // First requesting candidate in rotation order wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && req[cand[k]]) begin
        win_found = 1'b1;
        win_idx   = cand[k];
      end
    end
  end

  // State register plus all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 2'd0;
      hold_cnt_q    <= '0;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
      grant_q       <= 4'b0000;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
      grant_q       <= grant_d;
    end
  end

  // Next-state logic: tenure start, release, preemption and rotation pointer
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    preempt_evt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && win_found) begin
          state_d    = ST_GRANT;
          hold_cnt_d = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // A request drop wins over the hold limit: that is a normal release
        if (!req[grant_idx_q]) begin
          state_d = ST_GAP;
          ptr_d   = grant_idx_q + 2'd1;
        end else if (hold_cnt_q == HOLD_LIM) begin
          state_d     = ST_GAP;
          ptr_d       = grant_idx_q + 2'd1;
          preempt_evt = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs, grant = decode(idx) & valid
  always_comb begin
    grant_valid_d = (state_d == ST_GRANT);
    grant_idx_d   = ((state_q == ST_IDLE) && (state_d == ST_GRANT)) ? win_idx : grant_idx_q;
    preempt_d     = preempt_evt;
    grant_d       = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      grant_d[k] = grant_valid_d && (grant_idx_d == 2'(k));
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter (HOLD_MAX = 8).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int n_checks;
  int n_errors;

  decoder_rr_arbiter #(.HOLD_MAX(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction: compare all four outputs against expected values
  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                           input logic v, input logic p);
    $display("t=%0t %s req=%b en=%b grant=%b idx=%0d valid=%b preempt=%b",
             $time, tag, req, en, grant, grant_idx, grant_valid, preempt);
    check({tag, ".grant"},       8'(grant),       8'(g));
    check({tag, ".grant_idx"},   8'(grant_idx),   8'(i));
    check({tag, ".grant_valid"}, 8'(grant_valid), 8'(v));
    check({tag, ".preempt"},     8'(preempt),     8'(p));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input logic [1:0] w);
    return 4'b0001 << w;
  endfunction

  initial begin
    logic [1:0] seq [5];
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    en  = 1'b1;
    req = 4'b1111;

    // T1: reset held two cycles with all requests asserted
    tick();
    check_out("t1_rst_c1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("t1_rst_c2", 4'b0000, 2'd0, 1'b0, 1'b0);

    // T3: all requesting, every tenure preempted after 8 cycles, rotation 0,1,2,3,0
    rst = 1'b0;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check_out($sformatf("t3_w%0d_c1", t), oh(seq[t]), seq[t], 1'b1, 1'b0);
      for (int c = 2; c <= 8; c++) begin
        tick();
        check_out($sformatf("t3_w%0d_c%0d", t, c), oh(seq[t]), seq[t], 1'b1, 1'b0);
      end
      tick();
      check_out($sformatf("t3_w%0d_gap", t), 4'b0000, seq[t], 1'b0, 1'b1);
      tick();
      check_out($sformatf("t3_w%0d_idle", t), 4'b0000, seq[t], 1'b0, 1'b0);
    end
    // Pointer now 1; drop everything and let the arbiter sit idle
    req = 4'b0000;
    tick();
    check_out("t3_quiet", 4'b0000, 2'd0, 1'b0, 1'b0);

    // T2: single requester 2 held 3 cycles, then released
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_out($sformatf("t2_c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    check_out("t2_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    check_out("t2_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // T4: pointer is 3, requesters 0 and 1 -> wrap to 0, then 1
    req = 4'b0011;
    tick();
    check_out("t4_w0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0010;
    tick();
    check_out("t4_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("t4_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("t4_w1", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t4_gap2", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    check_out("t4_idle2", 4'b0000, 2'd1, 1'b0, 1'b0);

    // T5: en gates new grants only; a running tenure ignores en
    en  = 1'b0;
    req = 4'b0010;
    tick();
    check_out("t5_blk1", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    check_out("t5_blk2", 4'b0000, 2'd1, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    check_out("t5_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    en = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_out($sformatf("t5_hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    check_out("t5_gap", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    check_out("t5_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    en = 1'b1;

    // Boundary: request drops on the very cycle the hold limit is reached -> no preempt
    req = 4'b0001;
    tick();
    check_out("lim_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check_out($sformatf("lim_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0000;
    tick();
    check_out("lim_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    check_out("lim_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // T6: reset in the middle of requester 3's tenure
    req = 4'b1000;
    tick();
    check_out("t6_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    check_out("t6_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_out("t6_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("t6_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_out("t6_gap", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    check_out("t6_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
